hi_lo_multdiv_sequencer: RTL and testbench
==========================================

Name: hi_lo_multdiv_sequencer

Overview:
- Iterative multiply/divide unit and HI/LO write sequencer for the MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and runs shift-add multiply or restoring divide over WIDTH cycles.
- Produces one-cycle HI/LO write-enable pulses with results, which feed the hi_lo_register_write path through the pipeline registers.
- Generates a stall when a later instruction needs HI/LO, or the unit, before the result is ready.

Parameters:
WIDTH, 32, operand width; HI/LO results are WIDTH bits each; iteration count = WIDTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start_execute  input  1  valid HI/LO-class instruction in execute this cycle
operation_execute  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no operation
source_a_execute  input  WIDTH  rs operand (multiplicand/dividend/MTxx data)
source_b_execute  input  WIDTH  rt operand (multiplier/divisor)
hi_lo_read_request_decode  input  1  MFHI/MFLO in decode
flush  input  1  squash in-flight operation
stall  output  1  hold fetch/decode/execute
busy  output  1  state != IDLE
hi_write_enable  output  1  one-cycle HI write pulse
lo_write_enable  output  1  one-cycle LO write pulse
hi_result  output  WIDTH  HI value, valid with hi_write_enable
lo_result  output  WIDTH  LO value, valid with lo_write_enable

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, iteration counter=0.
  - All outputs 0 except stall, which is combinational and 0 in IDLE.
  - Internal accumulators cleared.
  - Reset mid-operation discards the operation; no enable pulse follows.
- States: IDLE, MULTIPLY, DIVIDE, DONE.
- Accept:
  - Only in IDLE, when start_execute=1, flush=0 and operation_execute is 0..5.
  - Operands are captured at that edge.
  - Op 6/7, or start with flush=1, leaves the unit in IDLE.
- MULT/MULTU:
  - IDLE -> MULTIPLY.
  - Signed: operate on magnitudes and record sign = a[msb]^b[msb].
  - Each cycle: if multiplier bit0, add multiplicand into upper half of 2*WIDTH product (WIDTH+1-bit add, carry kept), then shift right 1.
  - After exactly WIDTH iterations -> DONE. If sign, the 2*WIDTH product is two's-complement negated.
- DIV/DIVU:
  - IDLE -> DIVIDE; restoring division on magnitudes over WIDTH iterations -> DONE.
  - Signed: quotient negated if signs differ; remainder takes sign of dividend.
  - -2^(WIDTH-1)/-1 gives quotient 0x80000000 (wraps), remainder 0.
  - Divide by zero (b==0, detected at accept), signed or unsigned: HI=source_a, LO=all ones, no sign fix. Still takes WIDTH iterations.
- MTHI/MTLO: IDLE -> DONE directly. Only the matching enable pulses, with result = source_a; the other result output is 0.
- DONE:
  - Lasts exactly one cycle; hi_write_enable and lo_write_enable are registered pulses (both for mult/div). HI=upper/remainder, LO=lower/quotient.
  - Then -> IDLE; results return to 0.
- Latency:
  - Accept edge -> enable pulse visible in cycle WIDTH+1 (33 for WIDTH=32) for mult/div.
  - Cycle 1 for MTHI/MTLO.
- stall = busy & (hi_lo_read_request_decode | start_execute).
  - Asserted in DONE as well, since the HI/LO register updates at the end of DONE.
  - A start held under stall is accepted in the first IDLE cycle.
- flush:
  - In MULTIPLY/DIVIDE: next state IDLE, no pulse.
  - In DONE: ignored; the pulse completes.
  - In IDLE: blocks accept.
  - Reset dominates flush.
- Counter: $clog2(WIDTH)+1 bits, cleared on accept, terminal at WIDTH-1.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy cycles 1..33; cycle 33: both enables=1, hi_result=0xFFFFFFFE, lo_result=0x00000001; cycle 34: enables 0, busy 0.
- MULT -3 x 5 -> hi_result=0xFFFFFFFF, lo_result=0xFFFFFFF1. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> hi=7, lo=0xFFFFFFFF after 33 cycles. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- MULTU started, hi_lo_read_request_decode held high -> stall=1 cycles 1..33 inclusive, 0 at cycle 34. Second MULT start held during busy -> accepted at cycle 34, its pulse at cycle 67.
- MTLO 0x1234 -> cycle 1: lo_write_enable=1, hi_write_enable=0, lo_result=0x1234, busy=1; cycle 2: idle.
- Reset low at iteration 10 -> all outputs 0 immediately, no pulse afterward. Flush at iteration 10 -> IDLE next cycle, no pulse. Flush during DONE -> pulse still delivered.

Source files
------------

// File: rtl/hi_lo_multdiv_sequencer.sv
// Iterative multiply/divide unit and HI/LO write sequencer for the MIPS pipeline.
// Shift-add multiply and restoring divide run WIDTH cycles, then emit one-cycle HI/LO write pulses.
module hi_lo_multdiv_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_execute,
   input  logic [2:0]       operation_execute,
   input  logic [WIDTH-1:0] source_a_execute,
   input  logic [WIDTH-1:0] source_b_execute,
   input  logic             hi_lo_read_request_decode,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             hi_write_enable,
   output logic             lo_write_enable,
   output logic [WIDTH-1:0] hi_result,
   output logic [WIDTH-1:0] lo_result
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StMultiply, StDivide, StDone} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic                 neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic                 hi_we_q, hi_we_d, lo_we_q, lo_we_d;
   logic [WIDTH-1:0]     hi_res_q, hi_res_d, lo_res_q, lo_res_d;

   logic                 is_signed, a_neg, b_neg, div_zero, last_iter;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       mul_sum, div_shift, div_trial;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   mul_step, div_step, prod_fixed;

   always_comb begin
      is_signed = (operation_execute == 3'd0) || (operation_execute == 3'd2);
      a_neg     = is_signed & source_a_execute[WIDTH-1];
      b_neg     = is_signed & source_b_execute[WIDTH-1];
      a_mag     = a_neg ? -source_a_execute : source_a_execute;
      b_mag     = b_neg ? -source_b_execute : source_b_execute;
      div_zero  = (source_b_execute == '0);
      last_iter = (cnt_q == CntW'(WIDTH - 1));

      // Multiply: acc = {partial product, remaining multiplier bits}; b_q holds the multiplicand.
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
      mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

      // Divide: acc = {partial remainder, dividend/quotient bits}; b_q holds the divisor.
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, b_q};
      div_ge    = (div_shift >= {1'b0, b_q});
      div_step  = div_ge ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

      prod_fixed = neg_lo_q ? -mul_step : mul_step;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      b_d      = b_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      hi_we_d  = 1'b0;
      lo_we_d  = 1'b0;
      hi_res_d = '0;
      lo_res_d = '0;

      unique case (state_q)
         StIdle: begin
            if (start_execute && !flush && (operation_execute <= 3'd5)) begin
               cnt_d = '0;
               case (operation_execute)
                  3'd0, 3'd1: begin
                     state_d  = StMultiply;
                     acc_d    = {{WIDTH{1'b0}}, b_mag};
                     b_d      = a_mag;
                     neg_lo_d = a_neg ^ b_neg;
                     neg_hi_d = 1'b0;
                  end
                  3'd2, 3'd3: begin
                     // Divide by zero on the raw dividend yields rem = a, quotient = all ones.
                     state_d  = StDivide;
                     acc_d    = {{WIDTH{1'b0}}, div_zero ? source_a_execute : a_mag};
                     b_d      = b_mag;
                     neg_lo_d = !div_zero & (a_neg ^ b_neg);
                     neg_hi_d = !div_zero & a_neg;
                  end
                  3'd4: begin
                     state_d  = StDone;
                     hi_we_d  = 1'b1;
                     hi_res_d = source_a_execute;
                  end
                  default: begin
                     state_d  = StDone;
                     lo_we_d  = 1'b1;
                     lo_res_d = source_a_execute;
                  end
               endcase
            end
         end
         StMultiply: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               acc_d = mul_step;
               cnt_d = cnt_q + 1'b1;
               if (last_iter) begin
                  state_d  = StDone;
                  hi_we_d  = 1'b1;
                  lo_we_d  = 1'b1;
                  hi_res_d = prod_fixed[2*WIDTH-1:WIDTH];
                  lo_res_d = prod_fixed[WIDTH-1:0];
               end
            end
         end
         StDivide: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               acc_d = div_step;
               cnt_d = cnt_q + 1'b1;
               if (last_iter) begin
                  state_d  = StDone;
                  hi_we_d  = 1'b1;
                  lo_we_d  = 1'b1;
                  hi_res_d = neg_hi_q ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
                  lo_res_d = neg_lo_q ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_we_q  <= 1'b0;
         lo_we_q  <= 1'b0;
         hi_res_q <= '0;
         lo_res_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         hi_we_q  <= hi_we_d;
         lo_we_q  <= lo_we_d;
         hi_res_q <= hi_res_d;
         lo_res_q <= lo_res_d;
      end
   end

   assign busy            = (state_q != StIdle);
   assign stall           = busy & (hi_lo_read_request_decode | start_execute);
   assign hi_write_enable = hi_we_q;
   assign lo_write_enable = lo_we_q;
   assign hi_result       = hi_res_q;
   assign lo_result       = lo_res_q;

endmodule

// File: tb/tb_hi_lo_multdiv_sequencer.sv
// Scoreboard bench for hi_lo_multdiv_sequencer: driver pushes model results, monitor checks pulses.
module tb_hi_lo_multdiv_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_execute = 1'b0;
   logic [2:0]  operation_execute = 3'd7;
   logic [31:0] source_a_execute = '0;
   logic [31:0] source_b_execute = '0;
   logic        hi_lo_read_request_decode = 1'b0;
   logic        flush = 1'b0;
   logic        stall, busy, hi_write_enable, lo_write_enable;
   logic [31:0] hi_result, lo_result;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      logic        hwe;
      logic        lwe;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];

   hi_lo_multdiv_sequencer #(.WIDTH(32)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .start_execute             (start_execute),
      .operation_execute         (operation_execute),
      .source_a_execute          (source_a_execute),
      .source_b_execute          (source_b_execute),
      .hi_lo_read_request_decode (hi_lo_read_request_decode),
      .flush                     (flush),
      .stall                     (stall),
      .busy                      (busy),
      .hi_write_enable           (hi_write_enable),
      .lo_write_enable           (lo_write_enable),
      .hi_result                 (hi_result),
      .lo_result                 (lo_result)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain 64-bit / integer arithmetic; cyc is the cycle the pulse must be seen.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input int acc);
      exp_t            e;
      longint          ps;
      longint unsigned pu;
      int              sa, sb;
      e.hwe = 1'b1;
      e.lwe = 1'b1;
      e.hi  = '0;
      e.lo  = '0;
      e.cyc = acc + 32;
      sa    = a;
      sb    = b;
      case (op)
         3'd0: begin
            ps = longint'(sa) * longint'(sb);
            {e.hi, e.lo} = ps;
         end
         3'd1: begin
            pu = {32'b0, a} * {32'b0, b};
            {e.hi, e.lo} = pu;
         end
         3'd2: begin
            if (b == 0) begin
               e.hi = a; e.lo = '1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.hi = 0; e.lo = 32'h8000_0000;
            end else begin
               e.lo = sa / sb; e.hi = sa % sb;
            end
         end
         3'd3: begin
            if (b == 0) begin
               e.hi = a; e.lo = '1;
            end else begin
               e.lo = a / b; e.hi = a % b;
            end
         end
         3'd4: begin
            e.lwe = 1'b0; e.hi = a; e.cyc = acc;
         end
         default: begin
            e.hwe = 1'b0; e.lo = a; e.cyc = acc;
         end
      endcase
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Drive one start for a single edge; returns the cyc value of the accept edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, output int n);
      @(negedge clk);
      start_execute     = 1'b1;
      operation_execute = op;
      source_a_execute  = a;
      source_b_execute  = b;
      @(posedge clk);
      #1;
      start_execute     = 1'b0;
      operation_execute = 3'd7;
      n = cyc;
      if (push && op <= 3'd5) exp_q.push_back(model(op, a, b, n));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (hi_write_enable || lo_write_enable) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse cyc=%0d hwe=%b lwe=%b hi=%h lo=%h required=no pulse",
                     cyc, hi_write_enable, lo_write_enable, hi_result, lo_result);
         end else begin
            e = exp_q.pop_front();
            if (hi_write_enable !== e.hwe || lo_write_enable !== e.lwe || hi_result !== e.hi ||
                lo_result !== e.lo || cyc != e.cyc) begin
               fails++;
               $display("FAIL pulse actual: cyc=%0d hwe=%b lwe=%b hi=%h lo=%h required: cyc=%0d hwe=%b lwe=%b hi=%h lo=%h",
                        cyc, hi_write_enable, lo_write_enable, hi_result, lo_result,
                        e.cyc, e.hwe, e.lwe, e.hi, e.lo);
            end
         end
      end else if (hi_result != 0 || lo_result != 0) begin
         tests++;
         fails++;
         $display("FAIL results_idle actual hi=%h lo=%h required 0", hi_result, lo_result);
      end
   end

   initial begin
      int          n;
      logic [2:0]  op;
      logic [31:0] a, b;

      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 0);
      check("reset_stall", 32'(stall), 0);
      check("reset_hi", hi_result, 0);
      check("reset_lo", lo_result, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // MULTU max*max with MFHI pending, plus a second start held through the stall.
      hi_lo_read_request_decode = 1'b1;
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, n);
      start_execute     = 1'b1;
      operation_execute = 3'd0;
      source_a_execute  = 32'hFFFF_FFFD;
      source_b_execute  = 32'd5;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         check($sformatf("busy_c%0d", k), 32'(busy), (k <= 33) ? 1 : 0);
         check($sformatf("stall_c%0d", k), 32'(stall), (k <= 33) ? 1 : 0);
      end
      @(posedge clk);
      #1;
      start_execute = 1'b0;
      operation_execute = 3'd7;
      hi_lo_read_request_decode = 1'b0;
      exp_q.push_back(model(3'd0, 32'hFFFF_FFFD, 32'd5, cyc));
      repeat (33) @(negedge clk);

      // Directed corners.
      issue(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, n); repeat (33) @(negedge clk);
      issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, n);         repeat (33) @(negedge clk);
      issue(3'd3, 32'd7, 32'd0, 1'b1, n);                 repeat (33) @(negedge clk);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, n); repeat (33) @(negedge clk);
      issue(3'd2, 32'hFFFF_FFF9, 32'd0, 1'b1, n);         repeat (33) @(negedge clk);

      issue(3'd5, 32'h1234, 32'h0, 1'b1, n);
      @(negedge clk);
      check("mtlo_busy_c1", 32'(busy), 1);
      @(negedge clk);
      check("mtlo_busy_c2", 32'(busy), 0);

      // Reset at iteration 10: outputs clear immediately, nothing completes later.
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, n);
      hi_lo_read_request_decode = 1'b1;
      repeat (10) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_stall", 32'(stall), 0);
      check("rst_mid_we", {30'b0, hi_write_enable, lo_write_enable}, 0);
      @(negedge clk);
      reset = 1'b1;
      hi_lo_read_request_decode = 1'b0;
      repeat (40) @(negedge clk);

      // Flush at iteration 10: IDLE next cycle, no pulse.
      issue(3'd2, 32'd1000, 32'd7, 1'b0, n);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_mid_busy", 32'(busy), 0);
      repeat (40) @(negedge clk);

      // Flush in IDLE blocks accept.
      @(negedge clk);
      flush = 1'b1;
      start_execute = 1'b1;
      operation_execute = 3'd4;
      source_a_execute = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      flush = 1'b0;
      start_execute = 1'b0;
      operation_execute = 3'd7;
      check("flush_idle_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);

      // Flush during DONE is ignored.
      issue(3'd1, 32'd12345, 32'd678, 1'b1, n);
      repeat (33) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_done_busy", 32'(busy), 0);

      // Randomized operations, including no-op codes 6/7.
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         issue(op, a, b, 1'b1, n);
         if (op <= 3'd3) begin
            repeat (33) @(negedge clk);
         end else begin
            @(negedge clk);
            if (op >= 3'd6) check("noop_busy", 32'(busy), 0);
         end
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
